// File: rtl/noc_axi_mst_arbiter_if.sv
// AXI request/response types for the NoC data path, and the bundle carrying
// the requester-side ports and the crossbar-side port of the master arbiter.
package noc_axi_pkg;
  localparam int AXI_NOC_ID_W = 4;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    logic [ADDR_W-1:0]       addr;
    logic [7:0]              len;
  } noc_axi_ax_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
  } noc_axi_w_t;

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    logic [DATA_W-1:0]       data;
    logic [1:0]              resp;
    logic                    last;
  } noc_axi_r_t;

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    logic [1:0]              resp;
  } noc_axi_b_t;

  typedef struct packed {
    noc_axi_ax_t aw;
    logic        aw_valid;
    noc_axi_w_t  w;
    logic        w_valid;
    logic        b_ready;
    noc_axi_ax_t ar;
    logic        ar_valid;
    logic        r_ready;
  } noc_axi_data_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    noc_axi_b_t b;
    logic       b_valid;
    noc_axi_r_t r;
    logic       r_valid;
  } noc_axi_data_rsp_t;
endpackage

interface noc_axi_mst_arbiter_if #(
  parameter int N_REQ = 3
) ();
  noc_axi_pkg::noc_axi_data_req_t slv_req [N_REQ];
  noc_axi_pkg::noc_axi_data_rsp_t slv_rsp [N_REQ];
  noc_axi_pkg::noc_axi_data_req_t mst_req;
  noc_axi_pkg::noc_axi_data_rsp_t mst_rsp;

  // slave: the arbiter itself; master: the tile requesters plus the crossbar
  modport slave  (input slv_req, input mst_rsp, output slv_rsp, output mst_req);
  modport master (output slv_req, output mst_rsp, input slv_rsp, input mst_req);
endinterface

// File: rtl/noc_axi_mst_arbiter.sv
// Round-robin AR/AW arbiter sharing one NoC AXI master among N_REQ requesters;
// AR/AW/R/B combinational, W ordered by a FIFO of granted AW indices (1-cycle, no bypass).
module noc_axi_mst_arbiter #(
  parameter int N_REQ        = 3,
  parameter int IN_ID_W      = 2,
  parameter int W_FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  noc_axi_mst_arbiter_if.slave axi_io,
  output logic                 err_o,
  output logic                 busy_o
);
  import noc_axi_pkg::*;

  localparam int PFX_W   = AXI_NOC_ID_W - IN_ID_W;
  localparam int FIFO_AW = $clog2(W_FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  typedef logic [PFX_W-1:0] idx_t;

  // Returns {found, index}: first valid at or after ptr, wrapping.
  function automatic logic [PFX_W:0] rr_pick(input logic [N_REQ-1:0] vld, input idx_t ptr);
    logic [PFX_W:0] res;
    int             k;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N_REQ;
      if (vld[k]) res = {1'b1, idx_t'(k)};
    end
    return res;
  endfunction

  idx_t              ar_ptr_q, ar_ptr_d, ar_gnt_q, ar_gnt_d;
  idx_t              aw_ptr_q, aw_ptr_d, aw_gnt_q, aw_gnt_d;
  logic              ar_lock_q, ar_lock_d, aw_lock_q, aw_lock_d;
  idx_t              mem_q [W_FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  ar_vld_vec, aw_vld_vec;
  logic [PFX_W:0]    ar_pick, aw_pick;
  idx_t              ar_sel, aw_sel, w_head, r_pfx, b_pfx;
  logic              ar_req, aw_req, ar_hs, aw_hs;
  logic              w_empty, w_full, w_vld, w_pop;

  noc_axi_data_req_t mst_req;
  noc_axi_data_rsp_t slv_rsp [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ar_vld_vec[i] = axi_io.slv_req[i].ar_valid;
      aw_vld_vec[i] = axi_io.slv_req[i].aw_valid;
    end
    ar_pick = rr_pick(ar_vld_vec, ar_ptr_q);
    aw_pick = rr_pick(aw_vld_vec, aw_ptr_q);
    ar_sel  = ar_lock_q ? ar_gnt_q : ar_pick[PFX_W-1:0];
    aw_sel  = aw_lock_q ? aw_gnt_q : aw_pick[PFX_W-1:0];
    w_empty = (cnt_q == '0);
    w_full  = (cnt_q == CNT_W'(W_FIFO_DEPTH));
    // Full is judged on the registered count, so a same-cycle pop does not unblock AW.
    ar_req  = !rst_i && (ar_lock_q ? axi_io.slv_req[ar_gnt_q].ar_valid : ar_pick[PFX_W]);
    aw_req  = !rst_i && !w_full &&
              (aw_lock_q ? axi_io.slv_req[aw_gnt_q].aw_valid : aw_pick[PFX_W]);
    ar_hs   = ar_req && axi_io.mst_rsp.ar_ready;
    aw_hs   = aw_req && axi_io.mst_rsp.aw_ready;
    w_head  = mem_q[rd_q];
    w_vld   = !rst_i && !w_empty && axi_io.slv_req[w_head].w_valid;
    w_pop   = w_vld && axi_io.mst_rsp.w_ready && axi_io.slv_req[w_head].w.last;
    r_pfx   = axi_io.mst_rsp.r.id[AXI_NOC_ID_W-1:IN_ID_W];
    b_pfx   = axi_io.mst_rsp.b.id[AXI_NOC_ID_W-1:IN_ID_W];
  end

  always_comb begin
    ar_ptr_d  = ar_hs ? idx_t'((int'(ar_sel) + 1) % N_REQ) : ar_ptr_q;
    aw_ptr_d  = aw_hs ? idx_t'((int'(aw_sel) + 1) % N_REQ) : aw_ptr_q;
    ar_lock_d = ar_req && !axi_io.mst_rsp.ar_ready;
    aw_lock_d = aw_req && !axi_io.mst_rsp.aw_ready;
    ar_gnt_d  = ar_sel;
    aw_gnt_d  = aw_sel;
    wr_d      = wr_q + FIFO_AW'(aw_hs);
    rd_d      = rd_q + FIFO_AW'(w_pop);
    cnt_d     = cnt_q + CNT_W'(aw_hs) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_ptr_q  <= '0;
      aw_ptr_q  <= '0;
      ar_gnt_q  <= '0;
      aw_gnt_q  <= '0;
      ar_lock_q <= 1'b0;
      aw_lock_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      ar_ptr_q  <= ar_ptr_d;
      aw_ptr_q  <= aw_ptr_d;
      ar_gnt_q  <= ar_gnt_d;
      aw_gnt_q  <= aw_gnt_d;
      ar_lock_q <= ar_lock_d;
      aw_lock_q <= aw_lock_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) mem_q[wr_q] <= aw_sel;
  end

  always_comb begin
    mst_req = '0;
    for (int i = 0; i < N_REQ; i++) slv_rsp[i] = '0;
    err_o  = 1'b0;
    busy_o = 1'b0;
    if (!rst_i) begin
      mst_req.ar       = axi_io.slv_req[ar_sel].ar;
      mst_req.ar.id    = {ar_sel, axi_io.slv_req[ar_sel].ar.id[IN_ID_W-1:0]};
      mst_req.ar_valid = ar_req;
      slv_rsp[ar_sel].ar_ready = ar_hs;

      mst_req.aw       = axi_io.slv_req[aw_sel].aw;
      mst_req.aw.id    = {aw_sel, axi_io.slv_req[aw_sel].aw.id[IN_ID_W-1:0]};
      mst_req.aw_valid = aw_req;
      slv_rsp[aw_sel].aw_ready = aw_hs;

      if (!w_empty) begin
        mst_req.w       = axi_io.slv_req[w_head].w;
        mst_req.w_valid = w_vld;
        slv_rsp[w_head].w_ready = axi_io.mst_rsp.w_ready;
      end

      // Responses whose prefix names no requester are accepted and flagged.
      if (int'(r_pfx) < N_REQ) begin
        slv_rsp[r_pfx].r       = axi_io.mst_rsp.r;
        slv_rsp[r_pfx].r.id    = {{PFX_W{1'b0}}, axi_io.mst_rsp.r.id[IN_ID_W-1:0]};
        slv_rsp[r_pfx].r_valid = axi_io.mst_rsp.r_valid;
        mst_req.r_ready        = axi_io.slv_req[r_pfx].r_ready;
      end else begin
        mst_req.r_ready = 1'b1;
        err_o           = axi_io.mst_rsp.r_valid;
      end

      if (int'(b_pfx) < N_REQ) begin
        slv_rsp[b_pfx].b       = axi_io.mst_rsp.b;
        slv_rsp[b_pfx].b.id    = {{PFX_W{1'b0}}, axi_io.mst_rsp.b.id[IN_ID_W-1:0]};
        slv_rsp[b_pfx].b_valid = axi_io.mst_rsp.b_valid;
        mst_req.b_ready        = axi_io.slv_req[b_pfx].b_ready;
      end else begin
        mst_req.b_ready = 1'b1;
        err_o           = err_o | axi_io.mst_rsp.b_valid;
      end

      busy_o = !w_empty || ar_req || aw_req;
    end
  end

  assign axi_io.mst_req = mst_req;
  assign axi_io.slv_rsp = slv_rsp;
endmodule

// File: doc/noc_axi_mst_arbiter.md
# noc_axi_mst_arbiter

Shares a tile's single AXI master port onto the mesh NoC crossbar among three tile-internal requesters: 0 = instruction cache, 1 = iDMA, 2 = core data. Arbitrates AR and AW channels round-robin and prefixes each request ID with the requester index. Orders W beats to match granted AWs and routes R/B responses back by ID prefix. Sits between the tile's internal AXI masters and the NoC slave port of `mesh_xbar`, which uses `AXI_NOC_ID_W` = 4 (2 select bits + 2 original ID bits).

## Interface
- `N_REQ`, 3: number of requesters; 2..4.
- `IN_ID_W`, 2: requester ID bits kept; `AXI_NOC_ID_W - IN_ID_W` = 2 prefix bits.
- `W_FIFO_DEPTH`, 4: granted AWs whose W burst is not yet complete; power of 2.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `slv_req_i`  in  `N_REQ` x `noc_axi_data_req_t`  requester requests; ID bits above `IN_ID_W` ignored.
- `slv_rsp_o`  out  `N_REQ` x `noc_axi_data_rsp_t`  requester responses; upper ID bits driven 0.
- `mst_req_o`  out  `noc_axi_data_req_t`  to NoC crossbar.
- `mst_rsp_i`  in  `noc_axi_data_rsp_t`  from NoC crossbar.
- `err_o`  out  1  one-cycle pulse: R/B response carrying an out-of-range prefix was dropped.
- `busy_o`  out  1  W FIFO non-empty, or any AR/AW valid pending on `mst_req_o`.

## Operation
- **AR arbiter**
  - Round-robin pointer `ar_ptr`. Grant goes to the lowest index ≥ `ar_ptr` with `ar_valid`, wrapping.
  - Output: `mst.ar` = granted `ar` with `id` = {index, `id[IN_ID_W-1:0]`}.
  - Grant lock: once `mst.ar_valid` is asserted, the grant holds until `ar_ready` (AXI stability). On handshake, `ar_ptr` ← granted+1 mod `N_REQ`.
  - Only the granted requester sees `ar_ready`.
- **AW arbiter**
  - Same scheme with `aw_ptr`.
  - Additionally blocked, with `mst.aw_valid` = 0, while the W FIFO is full.
  - On AW handshake, the granted index is pushed into the W FIFO.
- **W path**
  - FIFO head selects the requester: `mst.w` = its `w`, and `w_ready` is returned only to it.
  - On a W handshake with `w.last`, the FIFO pops.
  - FIFO empty → `mst.w_valid` = 0 and all requester `w_ready` = 0. W beats presented early by requesters stall.
- **R/B routing**
  - Prefix `p` = `id[AXI_NOC_ID_W-1:IN_ID_W]`. Response goes to requester `p` with the prefix stripped; `mst.r_ready` / `b_ready` = that requester's ready.
  - `p` ≥ `N_REQ`: the response is sunk (ready = 1) and `err_o` pulses once per beat (R) or per response (B).
- R and B are independent; both may route in the same cycle, to the same or different requesters.

## Timing
- **Reset (async assert)**
  - Every valid and ready output = 0, `err_o` = 0, `busy_o` = 0.
  - Pointers = 0, W FIFO empty, grant locks cleared.
  - Reset mid-burst discards FIFO contents; no W beat is forwarded after reset until a new AW handshake.
- **Latency**
  - AR/AW: combinational, 0 cycles requester → `mst_req_o` when unlocked.
  - W: first beat usable the cycle after its AW handshake. There is no same-cycle bypass, even when the FIFO is empty.
  - R/B: combinational, 0 cycles.
- **Simultaneous events**
  - Push and pop in the same cycle allowed, including when full: pop frees the slot, but the full check uses the pre-pop count, so AW stays blocked that cycle.
  - Lock release and new arbitration happen in the same cycle only through the pointer update; the next grant is evaluated the following cycle.
- **Throughput**: one AR and one AW per cycle, back-to-back from different requesters.

## Test plan
- Requesters 0, 1, 2 all assert AR with `id` = 1, `ar_ready` = 1 → grants 0, 1, 2 on consecutive cycles; output ids 0x1, 0x5, 0x9; a second round starts again at 0.
- Requester 1 asserts AR; `ar_ready` held low 5 cycles while requester 0 also asserts → `mst.ar` stays requester 1 (id prefix 1) until handshake, then requester 0 is granted.
- Requesters 2 then 0 issue AW with 4-beat bursts, W ready always → W beats: 4 from requester 2, then 4 from requester 0; requester 0's early W is stalled; B with id 0x8 goes to requester 2 with id 0.
- 5 AWs with `w_valid` withheld and `W_FIFO_DEPTH` = 4 → 4 AW handshakes, the fifth blocked until one `w.last` handshake, then accepted the following cycle.
- R beat with id 0xC (prefix 3, `N_REQ` = 3) → `r_ready` = 1, no requester `r_valid`, `err_o` high for exactly 1 cycle.
- Assert `rst_i` during beat 2 of a 4-beat write → all valids and readies 0 immediately; after release, `busy_o` = 0 and no W is forwarded until a new AW.
